// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, LCR field positions, FIFO sizing.
// Reused by both the transmit and receive engines.
package uart_pkg;

  localparam int FIFO_DEPTH = 16;
  localparam int FIFO_AW    = 4;

  localparam int LCR_WLS = 0;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP  = 5;
  localparam int LCR_BRK = 6;

  typedef enum logic [3:0] {
    IDLE,
    START,
    BIT0,
    BIT1,
    BIT2,
    BIT3,
    BIT4,
    BIT5,
    BIT6,
    BIT7,
    PARITY,
    STOP1,
    STOP2
  } tx_fsm_t;

  // Keeps parity from seeing data bits beyond the word length
  function automatic logic [7:0] wl_mask(logic [1:0] wls);
    case (wls)
      2'b00:   return 8'h1F;
      2'b01:   return 8'h3F;
      2'b10:   return 8'h7F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit holding FIFO, 8 bits by 16 entries.
// A push against a full FIFO is dropped even when a pop happens the same cycle.
module uart_tx_fifo
  import uart_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic [4:0] count,
  output logic       empty,
  output logic       full
);

  logic [7:0]         mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty   = (count == 5'd0);
  assign full    = (count == 5'(FIFO_DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge PCLK) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 4'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 4'd1;
      count <= count + {4'd0, do_push} - {4'd0, do_pop};
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-fed framer with 16x oversampled bit timing.
// TXD is registered from the next state so line level and state stay aligned.
module uart_tx_engine
  import uart_pkg::*;
(
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       enable,
  input  logic [7:0] LCR,
  input  logic       push_tx_fifo,
  input  logic [7:0] tx_data,
  output logic       TXD,
  output logic       tx_idle,
  output logic [4:0] tx_fifo_count,
  output logic       tx_fifo_empty,
  output logic       tx_fifo_full
);

  tx_fsm_t    state;
  tx_fsm_t    state_d;
  tx_fsm_t    after_data;
  logic [3:0] bit_counter;
  logic [7:0] tx_buffer;
  logic [5:0] lcr_q;
  logic [7:0] fifo_dout;
  logic       pop;
  logic       tick_end;
  logic       par_bit;
  logic       line_d;
  logic       lcr_unused;

  assign lcr_unused = LCR[7];
  assign tx_idle    = (state == IDLE);
  assign tick_end   = enable && (bit_counter == 4'hF);
  assign after_data = lcr_q[LCR_PEN] ? PARITY : STOP1;

  always_comb begin
    logic [7:0] d;
    d = tx_buffer & wl_mask(lcr_q[1:0]);
    if (lcr_q[LCR_SP]) par_bit = ~lcr_q[LCR_EPS];
    else if (lcr_q[LCR_EPS]) par_bit = ^d;
    else par_bit = ~^d;
  end

  uart_tx_fifo u_fifo (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .push  (push_tx_fifo),
    .pop   (pop),
    .din   (tx_data),
    .dout  (fifo_dout),
    .count (tx_fifo_count),
    .empty (tx_fifo_empty),
    .full  (tx_fifo_full)
  );

  always_comb begin
    state_d = state;
    pop     = 1'b0;
    if (state == IDLE) begin
      if (!tx_fifo_empty) begin
        pop     = 1'b1;
        state_d = START;
      end
    end else if (tick_end) begin
      case (state)
        START:  state_d = BIT0;
        BIT0:   state_d = BIT1;
        BIT1:   state_d = BIT2;
        BIT2:   state_d = BIT3;
        BIT3:   state_d = BIT4;
        BIT4:   state_d = (lcr_q[1:0] == 2'd0) ? after_data : BIT5;
        BIT5:   state_d = (lcr_q[1:0] == 2'd1) ? after_data : BIT6;
        BIT6:   state_d = (lcr_q[1:0] == 2'd2) ? after_data : BIT7;
        BIT7:   state_d = after_data;
        PARITY: state_d = STOP1;
        STOP1:  state_d = lcr_q[LCR_STB] ? STOP2 : IDLE;
        STOP2:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    line_d = 1'b1;
    case (state_d)
      START:  line_d = 1'b0;
      BIT0:   line_d = tx_buffer[0];
      BIT1:   line_d = tx_buffer[1];
      BIT2:   line_d = tx_buffer[2];
      BIT3:   line_d = tx_buffer[3];
      BIT4:   line_d = tx_buffer[4];
      BIT5:   line_d = tx_buffer[5];
      BIT6:   line_d = tx_buffer[6];
      BIT7:   line_d = tx_buffer[7];
      PARITY: line_d = par_bit;
      default: line_d = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state       <= IDLE;
      bit_counter <= '0;
      tx_buffer   <= '0;
      lcr_q       <= '0;
      TXD         <= 1'b1;
    end else begin
      state <= state_d;
      TXD   <= LCR[LCR_BRK] ? 1'b0 : line_d;
      if (pop) begin
        tx_buffer   <= fifo_dout;
        lcr_q       <= LCR[5:0];
        bit_counter <= '0;
      end else if (state != IDLE && enable) begin
        bit_counter <= bit_counter + 4'd1;
      end
    end
  end

  a_idle_high: assert property (@(posedge PCLK) disable iff (PRESET)
    (state == IDLE && !$past(LCR[LCR_BRK])) |-> TXD);

  a_pop_ok: assert property (@(posedge PCLK) disable iff (PRESET)
    pop |-> (state == IDLE && !tx_fifo_empty));

  a_start_cnt: assert property (@(posedge PCLK) disable iff (PRESET)
    (state == START && $past(state) != START) |-> (bit_counter == 4'd0));

endmodule

// File: tb/tb_uart_tx_engine.sv
// Scoreboard bench for uart_tx_engine: expected frames queued at stimulus,
// a line monitor samples TXD mid-bit and checks frame length.
module tb_uart_tx_engine;

  typedef struct {
    logic [11:0] bits;
    int          n;
  } frame_t;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] LCR = 8'h00;
  logic       push_tx_fifo = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       TXD;
  logic       tx_idle;
  logic [4:0] tx_fifo_count;
  logic       tx_fifo_empty;
  logic       tx_fifo_full;

  int     checks = 0;
  int     errors = 0;
  bit     en_on = 1'b0;
  int     div = 0;
  frame_t exp_q[$];
  frame_t cur;
  bit     in_frame = 1'b0;
  bit     spur = 1'b0;
  int     ticks = 0;

  uart_tx_engine dut (
    .PCLK         (PCLK),
    .PRESET       (PRESET),
    .enable       (enable),
    .LCR          (LCR),
    .push_tx_fifo (push_tx_fifo),
    .tx_data      (tx_data),
    .TXD          (TXD),
    .tx_idle      (tx_idle),
    .tx_fifo_count(tx_fifo_count),
    .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_full (tx_fifo_full)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    forever begin
      @(posedge PCLK);
      #1;
      div = (div + 1) % 4;
      enable = en_on && (div == 0);
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Line monitor: samples at tick 8 of each bit, checks idle right after the last tick
  always @(negedge PCLK) begin
    logic exp_bit;
    if (PRESET) begin
      in_frame = 1'b0;
    end else if (in_frame && ticks == cur.n * 16) begin
      checks++;
      if (tx_idle !== 1'b1) begin
        errors++;
        $display("FAIL frame_len: tx_idle=%b expected 1 after %0d ticks",
                 tx_idle, ticks);
      end
      in_frame = 1'b0;
    end else begin
      if (tx_idle) spur = 1'b0;
      if (!in_frame && tx_idle === 1'b0) begin
        if (exp_q.size() == 0) begin
          if (!spur) begin
            checks++;
            errors++;
            $display("FAIL spurious_frame: frame started with nothing expected");
            spur = 1'b1;
          end
        end else begin
          cur = exp_q.pop_front();
          in_frame = 1'b1;
          ticks = 0;
        end
      end
      if (in_frame && enable) begin
        if (ticks % 16 == 8) begin
          exp_bit = LCR[6] ? 1'b0 : cur.bits[ticks / 16];
          checks++;
          if ({tx_idle, TXD} !== {1'b0, exp_bit}) begin
            errors++;
            $display("FAIL line_bit%0d: idle=%b txd=%b expected idle=0 txd=%b",
                     ticks / 16, tx_idle, TXD, exp_bit);
          end
        end
        ticks++;
      end
    end
  end

  task automatic expect_frame(input logic [11:0] b, input int n);
    frame_t f;
    f.bits = b;
    f.n = n;
    exp_q.push_back(f);
  endtask

  task automatic push(input logic [7:0] d);
    tx_data = d;
    push_tx_fifo = 1'b1;
    @(posedge PCLK);
    #2;
    push_tx_fifo = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge PCLK);
      if (enable) k++;
    end
    #2;
  endtask

  task automatic wait_busy();
    int k = 0;
    while (tx_idle && k < 50) begin
      @(posedge PCLK);
      #2;
      k++;
    end
    check("frame_start", int'(tx_idle), 0);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (k < 20000 && !(exp_q.size() == 0 && !in_frame && tx_idle)) begin
      @(posedge PCLK);
      k++;
    end
    #2;
    checks++;
    if (k >= 20000) begin
      errors++;
      $display("FAIL drain_timeout: %0d frames left, expected 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("rst_txd", int'(TXD), 1);
    check("rst_idle", int'(tx_idle), 1);
    check("rst_count", int'(tx_fifo_count), 0);
    check("rst_empty", int'(tx_fifo_empty), 1);
    check("rst_full", int'(tx_fifo_full), 0);
    #1 PRESET = 1'b0;
    @(posedge PCLK);
    #2;

    // 8N1, 0x55
    LCR = 8'h03;
    en_on = 1'b1;
    expect_frame(12'h2AA, 10);
    push(8'h55);
    wait_drain();

    // 8 bits, even parity, 2 stop, 0xA7
    LCR = 8'h1F;
    expect_frame(12'hF4E, 12);
    push(8'hA7);
    wait_drain();

    // 5 bits odd parity, stalled in STOP1 while the FIFO overfills
    LCR = 8'h08;
    expect_frame(12'h0BE, 8);
    for (int i = 0; i < 16; i++)
      expect_frame({1'b1, 1'b1, 8'(i), 1'b0}, 11);
    push(8'h1F);
    wait_busy();
    wait_ticks(116);
    en_on = 1'b0;
    LCR = 8'h07;
    for (int i = 0; i <= 16; i++) push(8'(i));
    check("ovf_count", int'(tx_fifo_count), 16);
    check("ovf_full", int'(tx_fifo_full), 1);
    check("ovf_empty", int'(tx_fifo_empty), 0);
    check("stall_busy", int'(tx_idle), 0);
    en_on = 1'b1;
    wait_drain();
    check("drain_count", int'(tx_fifo_count), 0);
    check("drain_empty", int'(tx_fifo_empty), 1);

    // Break from mid BIT3 for 40 ticks, then a clean frame
    LCR = 8'h03;
    expect_frame(12'h3FE, 10);
    expect_frame(12'h278, 10);
    push(8'hFF);
    push(8'h3C);
    wait_busy();
    wait_ticks(68);
    LCR = 8'h43;
    @(posedge PCLK);
    #2;
    check("brk_txd", int'(TXD), 0);
    wait_ticks(39);
    LCR = 8'h03;
    wait_drain();

    // Reset during BIT5 with three bytes queued
    expect_frame({2'b01, 8'h11, 1'b0}, 10);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    wait_busy();
    wait_ticks(100);
    check("pre_rst_count", int'(tx_fifo_count), 3);
    PRESET = 1'b1;
    exp_q.delete();
    @(posedge PCLK);
    @(negedge PCLK);
    check("abort_txd", int'(TXD), 1);
    check("abort_idle", int'(tx_idle), 1);
    check("abort_count", int'(tx_fifo_count), 0);
    check("abort_empty", int'(tx_fifo_empty), 1);
    check("abort_full", int'(tx_fifo_full), 0);
    #1 PRESET = 1'b0;
    repeat (3000) @(posedge PCLK);
    #2;
    check("post_rst_idle", int'(tx_idle), 1);
    check("post_rst_txd", int'(TXD), 1);
    check("left_expected", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
